// File: rtl/cla_adder_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cla_adder_pipe
// Purpose  : Pipelined carry-lookahead adder/subtractor with valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module cla_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] w_beff;
    logic [WIDTH-1:0] w_a_p;
    logic [WIDTH-1:0] w_a_g;
    logic [NG-1:0]    w_a_gg;
    logic [NG-1:0]    w_a_gp;
    logic             w_a_c0;

    logic [WIDTH-1:0] w_b_p;
    logic [WIDTH-1:0] w_b_g;
    logic [NG-1:0]    w_b_gg;
    logic [NG-1:0]    w_b_gp;
    logic             w_b_c0;
    logic [NG:0]      w_b_c;
    logic             w_term;

    logic [WIDTH-1:0] w_c_p;
    logic [WIDTH-1:0] w_c_g;
    logic [NG:0]      w_c_c;
    logic             w_cc;
    logic             w_cmsb;

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_zero;

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_load;
    logic              w_acc;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    // Operand conditioning: subtraction is a + ~b + 1, so cin is overridden.
    always_comb begin
        w_beff = sub ? ~b : b;
        w_a_c0 = sub | cin;
        w_a_p  = a ^ w_beff;
        w_a_g  = a & w_beff;
    end

    always_comb begin
        w_a_gg = '0;
        w_a_gp = '0;
        for (int j = 0; j < NG; j++) begin
            w_a_gp[j] = 1'b1;
            for (int k = 0; k < GROUP; k++) begin
                w_a_gg[j] = w_a_g[j*GROUP+k] | (w_a_p[j*GROUP+k] & w_a_gg[j]);
                w_a_gp[j] = w_a_gp[j] & w_a_p[j*GROUP+k];
            end
        end
    end

    // Inter-group carries as a flat sum of products so no carry ripples
    // from one group's result into the next.
    always_comb begin
        w_term   = 1'b0;
        w_b_c    = '0;
        w_b_c[0] = w_b_c0;
        for (int j = 0; j < NG; j++) begin
            w_term = w_b_c0;
            for (int m = 0; m <= j; m++) begin
                w_term = w_term & w_b_gp[m];
            end
            w_b_c[j+1] = w_term;
            for (int i = 0; i <= j; i++) begin
                w_term = w_b_gg[i];
                for (int m = i + 1; m <= j; m++) begin
                    w_term = w_term & w_b_gp[m];
                end
                w_b_c[j+1] = w_b_c[j+1] | w_term;
            end
        end
    end

    always_comb begin
        w_sum  = '0;
        w_cc   = 1'b0;
        w_cmsb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i % GROUP == 0) begin
                w_cc = w_c_c[i/GROUP];
            end
            w_sum[i] = w_c_p[i] ^ w_cc;
            w_cmsb   = w_cc;
            w_cc     = w_c_g[i] | (w_c_p[i] & w_cc);
        end
        w_cout = w_c_c[NG];
        w_ovf  = w_cmsb ^ w_c_c[NG];
        w_zero = (w_sum == '0);
    end

    // A stage may load when it, or any stage ahead of it, has room to move.
    always_comb begin
        w_acc  = out_ready;
        w_load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_acc     = w_acc | ~r_vld[k];
            w_load[k] = w_acc;
        end
    end

    assign in_ready  = w_load[0] & ~rst;
    assign out_valid = r_vld[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= in_valid;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end
    end

    generate
        if (STAGES >= 2) begin : g_stage_pg
            logic [WIDTH-1:0] r_s1_p;
            logic [WIDTH-1:0] r_s1_g;
            logic [NG-1:0]    r_s1_gg;
            logic [NG-1:0]    r_s1_gp;
            logic             r_s1_c0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1_p  <= '0;
                    r_s1_g  <= '0;
                    r_s1_gg <= '0;
                    r_s1_gp <= '0;
                    r_s1_c0 <= 1'b0;
                end else if (w_load[0]) begin
                    r_s1_p  <= w_a_p;
                    r_s1_g  <= w_a_g;
                    r_s1_gg <= w_a_gg;
                    r_s1_gp <= w_a_gp;
                    r_s1_c0 <= w_a_c0;
                end
            end

            assign w_b_p  = r_s1_p;
            assign w_b_g  = r_s1_g;
            assign w_b_gg = r_s1_gg;
            assign w_b_gp = r_s1_gp;
            assign w_b_c0 = r_s1_c0;
        end else begin : g_nostage_pg
            assign w_b_p  = w_a_p;
            assign w_b_g  = w_a_g;
            assign w_b_gg = w_a_gg;
            assign w_b_gp = w_a_gp;
            assign w_b_c0 = w_a_c0;
        end

        if (STAGES == 3) begin : g_stage_carry
            logic [WIDTH-1:0] r_s2_p;
            logic [WIDTH-1:0] r_s2_g;
            logic [NG:0]      r_s2_c;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s2_p <= '0;
                    r_s2_g <= '0;
                    r_s2_c <= '0;
                end else if (w_load[1]) begin
                    r_s2_p <= w_b_p;
                    r_s2_g <= w_b_g;
                    r_s2_c <= w_b_c;
                end
            end

            assign w_c_p = r_s2_p;
            assign w_c_g = r_s2_g;
            assign w_c_c = r_s2_c;
        end else begin : g_nostage_carry
            assign w_c_p = w_b_p;
            assign w_c_g = w_b_g;
            assign w_c_c = w_b_c;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_load[STAGES-1]) begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output.
- Computes per-bit propagate/generate, per-group lookahead propagate/generate, inter-group carries, then sums.
- Register boundaries are placed between these phases according to STAGES.
- Sits in the adder library as the datapath adder for ALU/accumulator blocks; supersedes the fixed 2-bit combinational carry cell.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group; legal values 2, 4, 8.
- STAGES, 3, pipeline depth (1..3); equals latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  pipeline can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1: compute a-b (a + ~b + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset: all stage valid bits clear; sum, cout, ovf, zero = 0; out_valid = 0. in_ready becomes 1 on the first cycle after rst deasserts.
- Operand conditioning (input side, combinational):
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - p[i] = a[i]^b_eff[i]; g[i] = a[i]&b_eff[i].
- Group lookahead, per group j of GROUP bits:
  - Internal carries c[k+1] = g[k] | p[k]&c[k].
  - Group generate GG[j] = OR over k of g[k] & AND of p above k.
  - Group propagate GP[j] = AND of p.
- Inter-group carry: C[j+1] = GG[j] | GP[j]&C[j], with C[0] = c0, in lookahead form (not ripple) across groups.
- Stage mapping:
  - STAGES=3: reg after p/g/GG/GP; reg after inter-group carries; reg on sum/flags.
  - STAGES=2: p/g/GG/GP registered, then carries+sum registered.
  - STAGES=1: only the output register.
  - c0 travels with its transaction through every stage.
- Handshake:
  - Transfer occurs when valid & ready are both high on a rising edge.
  - Stage k loads when its valid is 0 or stage k+1 loads this cycle; the last stage's "next" is out_ready.
  - in_ready = (stage1 empty) | (stage1 loads).
  - Bubbles collapse; full throughput is 1 op/cycle when out_ready is held high.
- Output stability: while out_valid & !out_ready, sum/cout/ovf/zero hold stable and the pipeline fills behind the stall (up to STAGES entries). Further inputs are refused (in_ready=0) only when all stages are full.
- Ordering: results leave in accept order; no drop, no duplication.
- Simultaneous accept and emit when full: allowed; the occupancy count is unchanged.
- Reset mid-operation: in-flight transactions are discarded; no output is produced for them after reset.
- Data on non-valid stages is don't-care, but flags must never pulse out_valid.
- Width: all arithmetic is modulo 2^WIDTH; there is no sign extension inside.

Test Plan:
- Basic add, WIDTH=32, STAGES=3: a=0x0000_0001, b=0x0000_0002, cin=0 -> after 3 cycles sum=0x00000003, cout=0, ovf=0, zero=0, out_valid for exactly one cycle.
- Full carry chain: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, zero=1, ovf=0. Same with sub=1, a=b=0x1234_5678 -> sum=0, cout=1, zero=1.
- Signed overflow: a=0x7FFF_FFFF, b=1 -> sum=0x80000000, ovf=1, cout=0. With sub=1, a=0x8000_0000, b=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure: stream 8 ops back-to-back, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops after 3 entries, outputs hold stable, all 8 results emerge in order with no loss.
- Reset mid-flight: issue 3 ops, assert rst asynchronously between edges -> out_valid and outputs go to 0 immediately; no stale result appears after release.
- Parameter sweep: STAGES=1,2,3 with GROUP=2,4,8 on 1000 random ops checked against a reference a+b+c0 -> results match, and latency equals STAGES at full throughput.
